// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the byte-serial memory controller
// (request sizes, FSM states, IO region prefix, size-to-byte-count helper).
package mem_pkg;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  // The illegal encoding 2'b11 falls through to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store onto the shared 8-bit RAM/IO bus.
// Define MEM_CTRL_PERF_EN to add perf_rd_bytes / perf_wr_bytes byte counters.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_cancel,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_rd_bytes,
  output logic [31:0]           perf_wr_bytes
`endif
);

  state_e                state_q, state_d;
  logic                  own_ls_q, own_ls_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  replay_q, replay_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic [31:0]           if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;

  logic [2:0]            sidx, nxt;
  logic [ADDR_WIDTH-1:0] req_addr, wr_addr;

  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return a[RAM_ADDR_WIDTH -: 2] == IO_PREFIX;
  endfunction

  always_comb begin
    state_d    = state_q;
    own_ls_d   = own_ls_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    replay_d   = replay_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    // cnt_q is the byte whose address is on the bus; pend_q means mem_din
    // carries byte cnt_q-1, so sidx is the oldest byte not yet captured.
    sidx       = pend_q ? cnt_q - 3'd1 : cnt_q;
    nxt        = mem_wr_q ? cnt_q + 3'd1 : cnt_q;
    req_addr   = ls_req ? ls_addr : if_addr;
    wr_addr    = addr_q + ADDR_WIDTH'(nxt);

    case (state_q)
      S_IDLE: begin
        if (rdy_in && (ls_req || (if_req && !if_cancel))) begin
          own_ls_d = ls_req;
          addr_d   = req_addr;
          nbytes_d = ls_req ? size_bytes(ls_size) : 3'd4;
          wdata_d  = ls_wdata;
          cnt_d    = 3'd0;
          pend_d   = 1'b0;
          replay_d = 1'b0;
          rbuf_d   = '0;
          mem_a_d  = req_addr;
          if (ls_req && ls_wr) begin
            state_d    = S_WRITE;
            mem_dout_d = ls_wdata[7:0];
            mem_wr_d   = !(is_io(req_addr) && io_buffer_full);
          end else begin
            state_d  = S_READ;
            mem_wr_d = 1'b0;
          end
        end
      end

      S_READ: begin
        mem_wr_d = 1'b0;
        if (!rdy_in) begin
          // Host may own the bus: park the in-flight address for replay.
          replay_d = 1'b1;
          mem_a_d  = addr_q + ADDR_WIDTH'(sidx);
        end else if (!own_ls_q && if_cancel) begin
          state_d  = S_IDLE;
          mem_a_d  = '0;
          replay_d = 1'b0;
        end else if (replay_q) begin
          replay_d = 1'b0;
          cnt_d    = sidx + 3'd1;
          pend_d   = 1'b1;
          mem_a_d  = (sidx + 3'd1 < nbytes_q) ? addr_q + ADDR_WIDTH'(sidx + 3'd1) : '0;
        end else begin
          if (pend_q)
            rbuf_d[{sidx[1:0], 3'b000} +: 8] = mem_din;
          if (pend_q && sidx == nbytes_q - 3'd1) begin
            state_d = S_DONE;
            mem_a_d = '0;
            if (own_ls_q) begin
              ls_done_d  = 1'b1;
              ls_rdata_d = rbuf_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            pend_d  = 1'b1;
            mem_a_d = (cnt_q + 3'd1 < nbytes_q) ? addr_q + ADDR_WIDTH'(cnt_q + 3'd1) : '0;
          end
        end
      end

      S_WRITE: begin
        if (!rdy_in) begin
          mem_wr_d = 1'b0;
        end else if (nxt == nbytes_q) begin
          state_d   = S_DONE;
          mem_a_d   = '0;
          mem_wr_d  = 1'b0;
          ls_done_d = 1'b1;
        end else begin
          cnt_d      = nxt;
          mem_a_d    = wr_addr;
          mem_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          mem_wr_d   = !(is_io(wr_addr) && io_buffer_full);
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        mem_a_d  = '0;
        mem_wr_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      own_ls_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      nbytes_q   <= 3'd0;
      cnt_q      <= 3'd0;
      pend_q     <= 1'b0;
      replay_q   <= 1'b0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      own_ls_q   <= own_ls_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      replay_q   <= replay_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d;
  logic        rd_inc, wr_inc;

  // A byte counts once it is actually captured or committed to the bus.
  assign rd_inc = (state_q == S_READ) && rdy_in && !replay_q && pend_q &&
                  (own_ls_q || !if_cancel);
  assign wr_inc = (state_q == S_WRITE) && rdy_in && mem_wr_q;

  always_comb begin
    perf_rd_d = perf_rd_q + {31'b0, rd_inc};
    perf_wr_d = perf_wr_q + {31'b0, wr_inc};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      perf_rd_q <= perf_rd_d;
      perf_wr_q <= perf_wr_d;
    end
  end

  assign perf_rd_bytes = perf_rd_q;
  assign perf_wr_bytes = perf_wr_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl; stimulus queues the
// expected done pulses, bus writes and per-cycle probes, a monitor checks them.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_rd_bytes, perf_wr_bytes;
`endif

  mem_ctrl #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
`ifdef MEM_CTRL_PERF_EN
    , .perf_rd_bytes(perf_rd_bytes), .perf_wr_bytes(perf_wr_bytes)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM with 1-cycle read latency; while paused the host drives junk.
  logic [7:0] ram [0:262143];
  always @(posedge clk_in) begin
    if (cyc == 0) begin
      ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
      ram[18'h00102] <= 8'h00; ram[18'h00103] <= 8'h00;
      ram[18'h00200] <= 8'h11; ram[18'h00201] <= 8'h22;
      ram[18'h00202] <= 8'h33; ram[18'h00203] <= 8'h44;
      ram[18'h00040] <= 8'hEF; ram[18'h00041] <= 8'hBE;
      ram[18'h00042] <= 8'hAD; ram[18'h00043] <= 8'hDE;
      ram[18'h02000] <= 8'h00; ram[18'h02001] <= 8'hFF;
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    mem_din <= rdy_in ? ram[mem_a[17:0]] : 8'hEE;
  end

  typedef struct { bit is_ls; bit chk; logic [31:0] data; int cyc; } done_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { int cyc; int sig; logic [31:0] val; } probe_t;

  done_t  exp_done[$];
  wr_t    exp_wr[$];
  probe_t probes[$];

  int checks = 0, failures = 0, timeouts = 0;
  bit finish_req = 0, mon_done = 0;

  localparam int P_MEM_A = 0, P_MEM_WR = 1, P_IF_DATA = 2, P_LS_RDATA = 3,
                 P_MEM_DOUT = 4, P_IF_DONE = 5, P_LS_DONE = 6;

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      P_MEM_A:    return mem_a;
      P_MEM_WR:   return {31'b0, mem_wr};
      P_IF_DATA:  return if_data;
      P_LS_RDATA: return ls_rdata;
      P_MEM_DOUT: return {24'b0, mem_dout};
      P_IF_DONE:  return {31'b0, if_done};
      default:    return {31'b0, ls_done};
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin
    done_t  d;
    wr_t    w;
    forever begin
      @(negedge clk_in);
      if (if_done || ls_done) begin
        if (exp_done.size() == 0) chk(0, "unexpected_done", {30'b0, ls_done, if_done}, 32'h0);
        else begin
          d = exp_done.pop_front();
          chk(ls_done == d.is_ls, "done_owner", {31'b0, ls_done}, {31'b0, d.is_ls});
          chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
          if (d.chk)
            chk((d.is_ls ? ls_rdata : if_data) == d.data, d.is_ls ? "ls_rdata" : "if_data",
                d.is_ls ? ls_rdata : if_data, d.data);
        end
      end
      if (mem_wr) begin
        if (exp_wr.size() == 0) chk(0, "unexpected_write", mem_a, 32'h0);
        else begin
          w = exp_wr.pop_front();
          chk(mem_a == w.addr && mem_dout == w.data && cyc == w.cyc, "bus_write",
              {mem_a[15:0], mem_dout, cyc[7:0]}, {w.addr[15:0], w.data, w.cyc[7:0]});
        end
      end
      for (int i = probes.size() - 1; i >= 0; i--) begin
        if (probes[i].cyc == cyc) begin
          chk(sig_val(probes[i].sig) == probes[i].val,
              $sformatf("probe_sig%0d", probes[i].sig), sig_val(probes[i].sig), probes[i].val);
          probes.delete(i);
        end
      end
      if (finish_req && !mon_done) begin
        chk(exp_done.size() == 0, "pending_done", exp_done.size(), 0);
        chk(exp_wr.size() == 0, "pending_write", exp_wr.size(), 0);
        chk(probes.size() == 0, "pending_probe", probes.size(), 0);
        chk(timeouts == 0, "timeouts", timeouts, 0);
        mon_done = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic exp_d(input bit is_ls, input bit c, input logic [31:0] d, input int at);
    done_t e;
    e.is_ls = is_ls; e.chk = c; e.data = d; e.cyc = at;
    exp_done.push_back(e);
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [7:0] d, input int at);
    wr_t e;
    e.addr = a; e.data = d; e.cyc = at;
    exp_wr.push_back(e);
  endtask

  task automatic probe(input int at, input int s, input logic [31:0] v);
    probe_t p;
    p.cyc = at; p.sig = s; p.val = v;
    probes.push_back(p);
  endtask

  task automatic start_ls(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    ls_req = 1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = wd;
  endtask

  // Drops the finished requester's req at the done pulse, then steps to the
  // next cycle so the following request is seen in IDLE.
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_in);
      if (ls_done) begin ls_req = 0; seen = 1; end
      if (if_done) begin if_req = 0; seen = 1; end
    end
    if (!seen) begin
      timeouts++;
      if_req = 0; ls_req = 0;
    end
    tick();
  endtask

  initial begin
    int c0;
    rst_n_in = 0; rdy_in = 1; io_buffer_full = 0;
    if_req = 0; if_addr = 0; if_cancel = 0;
    ls_req = 0; ls_wr = 0; ls_size = 0; ls_addr = 0; ls_wdata = 0;

    for (int c = 1; c <= 2; c++) begin
      probe(c, P_MEM_A, 0); probe(c, P_MEM_WR, 0); probe(c, P_MEM_DOUT, 0);
      probe(c, P_IF_DONE, 0); probe(c, P_LS_DONE, 0);
      probe(c, P_IF_DATA, 0); probe(c, P_LS_RDATA, 0);
    end
    tick(); tick(); tick();
    rst_n_in = 1;
    tick();

    // Word fetch
    c0 = cyc;
    if_req = 1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      probe(c0 + 1 + k, P_MEM_A, 32'h100 + k);
      probe(c0 + 1 + k, P_MEM_WR, 0);
    end
    exp_d(0, 1, 32'h0000_0513, c0 + 6);
    wait_done();

    // Byte store, then half load sees it in the upper byte
    c0 = cyc;
    start_ls(1, 2'b00, 32'h2001, 32'h0000_00AB);
    exp_w(32'h2001, 8'hAB, c0 + 1);
    exp_d(1, 0, 0, c0 + 2);
    wait_done();
    c0 = cyc;
    start_ls(0, 2'b01, 32'h2000, 0);
    exp_d(1, 1, 32'h0000_AB00, c0 + 4);
    wait_done();

    // Word store, word / byte / illegal-size loads back
    c0 = cyc;
    start_ls(1, 2'b10, 32'h300, 32'h1234_5678);
    exp_w(32'h300, 8'h78, c0 + 1); exp_w(32'h301, 8'h56, c0 + 2);
    exp_w(32'h302, 8'h34, c0 + 3); exp_w(32'h303, 8'h12, c0 + 4);
    exp_d(1, 0, 0, c0 + 5);
    wait_done();
    c0 = cyc;
    start_ls(0, 2'b10, 32'h300, 0);
    exp_d(1, 1, 32'h1234_5678, c0 + 6);
    wait_done();
    c0 = cyc;
    start_ls(0, 2'b00, 32'h302, 0);
    exp_d(1, 1, 32'h0000_0034, c0 + 3);
    wait_done();
    c0 = cyc;
    start_ls(0, 2'b11, 32'h300, 0);
    exp_d(1, 1, 32'h1234_5678, c0 + 6);
    wait_done();

    // Simultaneous requests: LSU first, fetch after a pass through IDLE
    c0 = cyc;
    start_ls(0, 2'b10, 32'h40, 0);
    if_req = 1; if_addr = 32'h100;
    exp_d(1, 1, 32'hDEAD_BEEF, c0 + 6);
    exp_d(0, 1, 32'h0000_0513, c0 + 13);
    wait_done();
    wait_done();

    // Fetch cancelled mid-read; next load accepted normally
    c0 = cyc;
    if_req = 1; if_addr = 32'h200;
    probe(c0 + 4, P_MEM_A, 0);
    probe(c0 + 5, P_IF_DATA, 32'h0000_0513);
    exp_d(1, 1, 32'hDEAD_BEEF, c0 + 10);
    tick(); tick(); tick();
    if_cancel = 1;
    tick();
    if_cancel = 0; if_req = 0;
    start_ls(0, 2'b10, 32'h40, 0);
    wait_done();

    // rdy_in pause after byte1 address: byte1 replayed, junk never sampled
    c0 = cyc;
    if_req = 1; if_addr = 32'h200;
    probe(c0 + 5, P_MEM_WR, 0);
    probe(c0 + 8, P_MEM_A, 32'h201);
    probe(c0 + 9, P_MEM_A, 32'h202);
    exp_d(0, 1, 32'h4433_2211, c0 + 12);
    tick(); tick(); tick();
    rdy_in = 0;
    repeat (5) tick();
    rdy_in = 1;
    wait_done();

    // IO store stalled by a full buffer, then a RAM store unaffected by it
    c0 = cyc;
    io_buffer_full = 1;
    start_ls(1, 2'b00, 32'h30000, 32'h5A);
    probe(c0 + 2, P_MEM_WR, 0);
    exp_w(32'h30000, 8'h5A, c0 + 5);
    exp_d(1, 0, 0, c0 + 6);
    repeat (4) tick();
    io_buffer_full = 0;
    wait_done();
    c0 = cyc;
    io_buffer_full = 1;
    start_ls(1, 2'b00, 32'h2002, 32'h77);
    exp_w(32'h2002, 8'h77, c0 + 1);
    exp_d(1, 0, 0, c0 + 2);
    wait_done();
    io_buffer_full = 0;

    // Asynchronous reset mid-fetch: outputs clear at once, no done pulse
    c0 = cyc;
    if_req = 1; if_addr = 32'h100;
    probe(c0 + 2, P_MEM_A, 0);
    probe(c0 + 3, P_IF_DATA, 0);
    probe(c0 + 3, P_LS_RDATA, 0);
    tick(); tick();
    rst_n_in = 0; if_req = 0;
    tick(); tick();
    rst_n_in = 1;
    repeat (3) tick();

    finish_req = 1;
    for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk_in);
    if (!mon_done) begin
      $display("FAIL monitor_finish: monitor did not complete final checks");
      $fatal(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside `cpu`, directly upstream of the shared 8-bit RAM/IO bus (`mem_a`/`mem_dout`/`mem_din`/`mem_wr`).
- Arbitrates between the instruction fetcher (word reads) and the load/store unit (byte/half/word reads and writes).
- Splits each request into little-endian byte accesses and reassembles read data around the RAM's 1-cycle synchronous read latency.
- Honours the `rdy_in` pause and the IO buffer-full stall.

Parameters:
- ADDR_WIDTH, 32, width of request and bus addresses.
- RAM_ADDR_WIDTH, 17, RAM address width; the IO region is decoded as addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; one clock, asynchronous, active-low
- rdy_in  in  1  global ready; low = pause
- io_buffer_full  in  1  UART TX buffer full
- mem_din  in  8  bus read data; valid the cycle after its address
- mem_dout  out  8  bus write data
- mem_a  out  ADDR_WIDTH  bus byte address
- mem_wr  out  1  1=write, 0=read
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address, word-aligned
- if_cancel  in  1  abort pending/active fetch (mispredict flush)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched word
- ls_req  in  1  load/store request, level; held with payload until ls_done
- ls_wr  in  1  1=store
- ls_size  in  2  00 byte, 01 half, 10 word; 11 illegal, treated as word
- ls_addr  in  ADDR_WIDTH  byte address, naturally aligned
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended

Behaviour:
- Reset (rst_n_in low, async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0. A reset mid-transaction discards all progress; no done pulse is issued.
- All outputs are registered. N = bytes: 1, 2 or 4.
- States:
  - IDLE
  - READ
  - WRITE
  - DONE (pulse cycle)
- IDLE, accept:
  - ls_req has priority over if_req.
  - Latch request; byte counter k=0.
  - READ: drive mem_a=addr+0, mem_wr=0 next cycle. WRITE: mem_a=addr+0, mem_dout=byte0, mem_wr=1.
- READ:
  - Address of byte k is on the bus in cycle 1+k (k<N).
  - mem_din is sampled in cycle 2+k into bits [8k+7:8k].
  - After the last sample: DONE. mem_wr stays 0.
- Read latency: request seen in IDLE at cycle 0 -> done pulse in cycle N+2 (word=6, byte=3).
- WRITE:
  - Byte k is driven in cycle 1+k with mem_wr=1, then DONE.
  - Write latency: done in cycle N+1.
  - mem_wr returns to 0 in DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle with data; idle the bus (mem_a=0, mem_wr=0).
  - Requests are ignored this cycle; next arbitration happens in IDLE.
- if_cancel:
  - In IDLE: the fetch is not accepted.
  - During a fetch READ: abort to IDLE at the next edge, no if_done. The fetch data register is left unchanged.
  - No effect on an LSU transaction.
- io_buffer_full:
  - Applies to a WRITE whose address is in the IO region.
  - Before driving byte k, if io_buffer_full=1: hold with mem_wr=0 until it is 0.
- rdy_in=0:
  - Freeze state, counter and data; force mem_wr=0.
  - On return of rdy_in in READ, re-present the in-flight byte address for one cycle, then resume sampling. The bus may have been taken by the host meanwhile, so a stale sample must never be used.
- Address arithmetic: addr+k is modulo 2^ADDR_WIDTH.
- An LSU request arriving during a fetch waits; there is no preemption.

Optional Feature:
- MEM_CTRL_PERF_EN
- Defined: adds outputs perf_rd_bytes[31:0] and perf_wr_bytes[31:0].
  - Counting: +1 per byte sampled / per byte written.
  - Frozen while rdy_in=0; reset to 0; wrap at 2^32.
- Undefined: ports and logic are absent, and the controller is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - ls_size encodings (SIZE_B, SIZE_H, SIZE_W)
  - state enum
  - IO region prefix 2'b11
  - byte-count function size->N
- No sub-module; one FSM plus datapath.

Test Plan:
- Word fetch: ram[0x100..0x103]=13 05 00 00, if_req addr 0x100 at cycle 0 -> mem_a 0x100..0x103 in cycles 1-4, if_done cycle 6, if_data=0x00000513.
- Byte store: ls_wr=1, size 00, addr 0x2001, wdata 0xAB -> one mem_wr cycle at mem_a 0x2001, mem_dout 0xAB, ls_done cycle 2; half load from 0x2000 then returns 0x0000AB00 if ram[0x2000]=0.
- Simultaneous if_req and ls_req (load word 0x40) -> LSU served first, ls_done cycle 6; fetch starts after IDLE, if_done cycle 13.
- if_cancel asserted in cycle 3 of a fetch -> no if_done, returns to IDLE, next ls_req is accepted normally.
- rdy_in low for 5 cycles after byte1 address of a word read -> mem_wr stays 0, byte1 is re-presented, data is correct, done is delayed by 6 cycles.
- Store to 0x30000 with io_buffer_full=1 for 4 cycles -> no mem_wr until full drops, then single write, ls_done one cycle later.
